// File: rtl/mont_mul_seq_pkg.sv
// Shared definitions for the Montgomery multiplication sequencer:
// state encoding, default widths and adder opcodes.
package mont_mul_seq_pkg;

   localparam int N_DEF   = 1024;
   // Adder operands carry this many guard bits above N, so ADD_W = N + ADD_EXT.
   localparam int ADD_EXT = 4;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADD_B,
      S_WAIT_B,
      S_ADD_M,
      S_WAIT_M,
      S_SHIFT,
      S_SHIFT_CAP,
      S_SUB,
      S_WAIT_SUB,
      S_DONE
   } state_t;

endpackage

// File: rtl/mont_mul_seq.sv
// Bit-serial Montgomery multiplier sequencer: result = a*b*2^-N mod m,
// driving an external multi-cycle adder for every add, shift and final subtract.
module mont_mul_seq
   import mont_mul_seq_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int ADD_W = N + ADD_EXT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [N-1:0]     a_in,
   input  logic [N-1:0]     b_in,
   input  logic [N-1:0]     m_in,
   output logic             busy,
   output logic             done,
   output logic [N-1:0]     result,
   output logic             add_start,
   output logic             add_subtract,
   output logic             add_shift,
   output logic [ADD_W-1:0] add_in_a,
   output logic [ADD_W-1:0] add_in_b,
   input  logic [ADD_W:0]   add_result,
   input  logic             add_done
);

   localparam int               CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);

   state_t           state, state_nx;
   logic [N-1:0]     a_q, b_q, m_q, res_q;
   logic [ADD_W-1:0] c_q;
   logic [CNT_W-1:0] cnt;
   logic [ADD_W-1:0] b_ext, m_ext;

   assign b_ext    = {{(ADD_W-N){1'b0}}, b_q};
   assign m_ext    = {{(ADD_W-N){1'b0}}, m_q};
   assign add_in_a = c_q;
   assign result   = res_q;

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   // Operand B selections only change on capture edges, so they stay stable
   // from the add_start cycle through the cycle add_done is sampled.
   always_comb begin
      state_nx     = state;
      busy         = 1'b1;
      done         = 1'b0;
      add_start    = 1'b0;
      add_subtract = OP_ADD;
      add_shift    = 1'b0;
      add_in_b     = '0;
      unique case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_nx = S_ADD_B;
         end
         S_ADD_B: begin
            add_start = 1'b1;
            add_in_b  = a_q[cnt] ? b_ext : '0;
            state_nx  = S_WAIT_B;
         end
         S_WAIT_B: begin
            add_in_b = a_q[cnt] ? b_ext : '0;
            if (add_done) state_nx = S_ADD_M;
         end
         S_ADD_M: begin
            add_start = 1'b1;
            add_in_b  = c_q[0] ? m_ext : '0;
            state_nx  = S_WAIT_M;
         end
         S_WAIT_M: begin
            add_in_b = c_q[0] ? m_ext : '0;
            if (add_done) state_nx = S_SHIFT;
         end
         S_SHIFT: begin
            add_shift = 1'b1;
            state_nx  = S_SHIFT_CAP;
         end
         S_SHIFT_CAP: begin
            state_nx = (cnt == LAST) ? S_SUB : S_ADD_B;
         end
         S_SUB: begin
            add_start    = 1'b1;
            add_subtract = OP_SUB;
            add_in_b     = m_ext;
            state_nx     = S_WAIT_SUB;
         end
         S_WAIT_SUB: begin
            add_subtract = OP_SUB;
            add_in_b     = m_ext;
            if (add_done) state_nx = S_DONE;
         end
         S_DONE: begin
            busy     = 1'b0;
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: begin
            busy     = 1'b0;
            state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q   <= '0;
         b_q   <= '0;
         m_q   <= '0;
         c_q   <= '0;
         cnt   <= '0;
         res_q <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  a_q <= a_in;
                  b_q <= b_in;
                  m_q <= m_in;
                  c_q <= '0;
                  cnt <= '0;
               end
            end
            S_WAIT_B, S_WAIT_M: begin
               if (add_done) c_q <= add_result[ADD_W-1:0];
            end
            S_SHIFT_CAP: begin
               c_q <= add_result[ADD_W-1:0];
               if (cnt != LAST) cnt <= cnt + 1'b1;
            end
            // A borrow out of C-M means C was already below m.
            S_WAIT_SUB: begin
               if (add_done)
                  res_q <= add_result[ADD_W] ? c_q[N-1:0] : add_result[N-1:0];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mont_mul_seq.sv
// Directed bench for mont_mul_seq at N=8, m=0xF1 (R=2^8, R mod m=0x0F,
// R^-1 mod m=0xE1, R^2 mod m=0xE1) with a behavioural adder of latency lat.
module tb_mont_mul_seq;

   localparam int N     = 8;
   localparam int ADD_W = N + 4;
   localparam logic [N-1:0] MOD = 8'hF1;

   logic             clk = 1'b0;
   logic             reset, start;
   logic [N-1:0]     a_in, b_in, m_in;
   logic             busy, done;
   logic [N-1:0]     result;
   logic             add_start, add_subtract, add_shift;
   logic [ADD_W-1:0] add_in_a, add_in_b;
   logic [ADD_W:0]   add_result;
   logic             add_done;

   int n_tests = 0;
   int n_fail  = 0;
   int lat     = 1;

   always #5 clk = ~clk;

   mont_mul_seq #(.N(N), .ADD_W(ADD_W)) dut (
      .clk(clk), .reset(reset), .start(start),
      .a_in(a_in), .b_in(b_in), .m_in(m_in),
      .busy(busy), .done(done), .result(result),
      .add_start(add_start), .add_subtract(add_subtract), .add_shift(add_shift),
      .add_in_a(add_in_a), .add_in_b(add_in_b),
      .add_result(add_result), .add_done(add_done)
   );

   // Adder model: add_done and the new result appear lat cycles after add_start.
   logic [ADD_W:0] op_val, pend;
   int             rem;
   assign op_val = add_subtract ? ({1'b0, add_in_a} - {1'b0, add_in_b})
                                : ({1'b0, add_in_a} + {1'b0, add_in_b});

   always @(posedge clk) begin
      if (reset) begin
         add_done   <= 1'b0;
         add_result <= '0;
         pend       <= '0;
         rem        <= 0;
      end else begin
         add_done <= 1'b0;
         if (add_start) begin
            if (lat == 1) begin
               add_result <= op_val;
               add_done   <= 1'b1;
               rem        <= 0;
            end else begin
               pend <= op_val;
               rem  <= lat - 1;
            end
         end else if (rem > 0) begin
            rem <= rem - 1;
            if (rem == 1) begin
               add_result <= pend;
               add_done   <= 1'b1;
            end
         end
         if (add_shift) add_result <= add_result >> 1;
      end
   end

   // Inclusive cycle count from the start cycle through the done cycle.
   function automatic int exp_lat(input int t);
      return N * (2 * (t + 1) + 2) + (t + 1) + 2;
   endfunction

   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         output logic [N-1:0] res, output int cyc, output int nadd);
      bit got;
      @(negedge clk);
      a_in = a; b_in = b; m_in = MOD; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1; nadd = 0; got = 1'b0;
      while (!got && cyc < 1000) begin
         cyc++;
         if (add_start) nadd++;
         if (done) got = 1'b1;
         else @(negedge clk);
      end
      res = result;
      if (!got) cyc = -1;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; a_in = '0; b_in = '0; m_in = '0;
      repeat (3) @(negedge clk);
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", done); end
      n_tests++; if (result !== 8'h00) begin n_fail++; $display("FAIL rst_result got %h want 00", result); end
      n_tests++; if (add_start !== 1'b0) begin n_fail++; $display("FAIL rst_add_start got %b want 0", add_start); end
      n_tests++; if (add_shift !== 1'b0) begin n_fail++; $display("FAIL rst_add_shift got %b want 0", add_shift); end
      n_tests++; if (add_subtract !== 1'b0) begin n_fail++; $display("FAIL rst_add_sub got %b want 0", add_subtract); end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      logic [N-1:0] r; int c, na;
      lat = 1;
      run_op(8'h01, 8'h01, r, c, na);
      n_tests++; if (r !== 8'hE1) begin n_fail++; $display("FAIL basic_result got %h want e1", r); end
      n_tests++; if (c !== exp_lat(1)) begin n_fail++; $display("FAIL basic_latency got %0d want %0d", c, exp_lat(1)); end
      n_tests++; if (na !== 2*N+1) begin n_fail++; $display("FAIL basic_add_starts got %0d want %0d", na, 2*N+1); end
      @(negedge clk);
      n_tests++; if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL basic_after_done got %b want 00", {done, busy}); end
   endtask

   // Into Montgomery form with b=R^2 (7R mod m = 0x69), then back out with b=1.
   task automatic test_round_trip();
      logic [N-1:0] r; int c, na;
      run_op(8'h07, 8'hE1, r, c, na);
      n_tests++; if (r !== 8'h69) begin n_fail++; $display("FAIL rt_in_result got %h want 69", r); end
      n_tests++; if (c !== exp_lat(1)) begin n_fail++; $display("FAIL rt_in_latency got %0d want %0d", c, exp_lat(1)); end
      run_op(8'h69, 8'h01, r, c, na);
      n_tests++; if (r !== 8'h07) begin n_fail++; $display("FAIL rt_out_result got %h want 07", r); end
      n_tests++; if (c !== exp_lat(1)) begin n_fail++; $display("FAIL rt_out_latency got %0d want %0d", c, exp_lat(1)); end
   endtask

   task automatic test_zero();
      logic [N-1:0] r; int c, na;
      run_op(8'h00, 8'h55, r, c, na);
      n_tests++; if (r !== 8'h00) begin n_fail++; $display("FAIL zero_result got %h want 00", r); end
      n_tests++; if (na !== 2*N+1) begin n_fail++; $display("FAIL zero_add_starts got %0d want %0d", na, 2*N+1); end
      n_tests++; if (c !== exp_lat(1)) begin n_fail++; $display("FAIL zero_latency got %0d want %0d", c, exp_lat(1)); end
   endtask

   // (m-1)^2 * R^-1 = R^-1 = 0xE1;  15*15*R^-1 = R^2*R^-1 = R = 0x0F.
   task automatic test_boundary();
      logic [N-1:0] r; int c, na;
      run_op(8'hF0, 8'hF0, r, c, na);
      n_tests++; if (r !== 8'hE1) begin n_fail++; $display("FAIL bnd_max_result got %h want e1", r); end
      n_tests++; if (c !== exp_lat(1)) begin n_fail++; $display("FAIL bnd_max_latency got %0d want %0d", c, exp_lat(1)); end
      run_op(8'h0F, 8'h0F, r, c, na);
      n_tests++; if (r !== 8'h0F) begin n_fail++; $display("FAIL bnd_r_result got %h want 0f", r); end
      n_tests++; if (c !== exp_lat(1)) begin n_fail++; $display("FAIL bnd_r_latency got %0d want %0d", c, exp_lat(1)); end
   endtask

   // 2*3*R^-1 = 1350 mod 241 = 0x91.
   task automatic test_latency_t4();
      logic [N-1:0] r; int c, na;
      lat = 4;
      run_op(8'h02, 8'h03, r, c, na);
      n_tests++; if (r !== 8'h91) begin n_fail++; $display("FAIL t4_result got %h want 91", r); end
      n_tests++; if (c !== exp_lat(4)) begin n_fail++; $display("FAIL t4_latency got %0d want %0d", c, exp_lat(4)); end
      n_tests++; if (na !== 2*N+1) begin n_fail++; $display("FAIL t4_add_starts got %0d want %0d", na, 2*N+1); end
   endtask

   task automatic test_busy_start();
      int cyc; bit got; logic bsy;
      lat = 2;
      @(negedge clk);
      a_in = 8'h02; b_in = 8'h03; m_in = MOD; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1; got = 1'b0; bsy = 1'b0;
      while (!got && cyc < 1000) begin
         cyc++;
         if (cyc == 4) begin
            bsy = busy;
            a_in = 8'h01; b_in = 8'h01; m_in = 8'h0B; start = 1'b1;
         end
         if (cyc == 5) start = 1'b0;
         if (done) got = 1'b1;
         else @(negedge clk);
      end
      if (!got) cyc = -1;
      n_tests++; if (bsy !== 1'b1) begin n_fail++; $display("FAIL busy_flag got %b want 1", bsy); end
      n_tests++; if (result !== 8'h91) begin n_fail++; $display("FAIL busy_result got %h want 91", result); end
      n_tests++; if (cyc !== exp_lat(2)) begin n_fail++; $display("FAIL busy_latency got %0d want %0d", cyc, exp_lat(2)); end
   endtask

   task automatic test_reset_mid();
      logic [N-1:0] r; int c, na, seen, stray;
      lat = 3;
      @(negedge clk);
      a_in = 8'h01; b_in = 8'h01; m_in = MOD; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen = 0; c = 0;
      while (seen < 2 && c < 200) begin
         if (add_start) seen++;
         if (seen < 2) @(negedge clk);
         c++;
      end
      n_tests++; if (seen !== 2) begin n_fail++; $display("FAIL mid_reach_add_m got %0d want 2", seen); end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b want 0", busy); end
      n_tests++; if (result !== 8'h00) begin n_fail++; $display("FAIL mid_result_clear got %h want 00", result); end
      stray = 0;
      repeat (10) begin
         if (add_start || add_shift || done) stray++;
         @(negedge clk);
      end
      n_tests++; if (stray !== 0) begin n_fail++; $display("FAIL mid_stray_pulses got %0d want 0", stray); end
      run_op(8'h0F, 8'h0F, r, c, na);
      n_tests++; if (r !== 8'h0F) begin n_fail++; $display("FAIL mid_fresh_result got %h want 0f", r); end
      n_tests++; if (c !== exp_lat(3)) begin n_fail++; $display("FAIL mid_fresh_latency got %0d want %0d", c, exp_lat(3)); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_round_trip();
      test_zero();
      test_boundary();
      test_latency_t4();
      test_busy_start();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
